// File: rtl/text_cursor_ctrl.sv
// Text-mode cursor controller: writes characters into a tile RAM, advances a wrapping cursor, and clears the screen.
// Requests take one cycle of latency; while a clear is running (busy=1) every request pulse is dropped.
module text_cursor_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [6:0] BLANK = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_tick,
  input  logic [6:0] sw,
  output logic       we,
  output logic [6:0] addr_x,
  output logic [4:0] addr_y,
  output logic [6:0] din,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic       we_d, busy_d;
  logic [6:0] addr_x_d, din_d, cur_x_d, adv_x;
  logic [4:0] addr_y_d, cur_y_d, adv_y;

  always_comb begin
    adv_x = cur_x + 7'd1;
    adv_y = cur_y;
    if (cur_x == X_MAX) begin
      adv_x = 7'd0;
      adv_y = (cur_y == Y_MAX) ? 5'd0 : cur_y + 5'd1;
    end
  end

  // The write address registers double as the clear scan counter.
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    addr_x_d = addr_x;
    addr_y_d = addr_y;
    din_d    = din;
    cur_x_d  = cur_x;
    cur_y_d  = cur_y;
    case (state_q)
      IDLE: begin
        if (btn_tick[2]) begin
          state_d  = CLEAR;
          we_d     = 1'b1;
          busy_d   = 1'b1;
          addr_x_d = 7'd0;
          addr_y_d = 5'd0;
          din_d    = BLANK;
        end else if (btn_tick[0]) begin
          state_d  = WRITE;
          we_d     = 1'b1;
          addr_x_d = cur_x;
          addr_y_d = cur_y;
          din_d    = sw;
        end else if (btn_tick[1]) begin
          cur_x_d = adv_x;
          cur_y_d = adv_y;
        end
      end
      WRITE: begin
        // Cursor moves while we is high, so it is visible the cycle after the write.
        state_d = IDLE;
        cur_x_d = adv_x;
        cur_y_d = adv_y;
      end
      CLEAR: begin
        if (addr_x == X_MAX && addr_y == Y_MAX) begin
          state_d = IDLE;
          cur_x_d = 7'd0;
          cur_y_d = 5'd0;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          if (addr_x == X_MAX) begin
            addr_x_d = 7'd0;
            addr_y_d = addr_y + 5'd1;
          end else begin
            addr_x_d = addr_x + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we      <= 1'b0;
      busy    <= 1'b0;
      addr_x  <= 7'd0;
      addr_y  <= 5'd0;
      din     <= 7'd0;
      cur_x   <= 7'd0;
      cur_y   <= 5'd0;
    end else begin
      state_q <= state_d;
      we      <= we_d;
      busy    <= busy_d;
      addr_x  <= addr_x_d;
      addr_y  <= addr_y_d;
      din     <= din_d;
      cur_x   <= cur_x_d;
      cur_y   <= cur_y_d;
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: expected tile-RAM writes are queued by the stimulus and popped by a monitor on every we.
module tb_text_cursor_ctrl;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] y;
    logic [6:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn_tick = 3'b000;
  logic [6:0] sw = 7'h00;
  logic       we, busy;
  logic [6:0] addr_x, din, cur_x;
  logic [4:0] addr_y, cur_y;

  int  checks = 0;
  int  errors = 0;
  int  we_cnt = 0;
  wr_t exp_q[$];

  text_cursor_ctrl #(.COLS(80), .ROWS(30), .BLANK(7'h00)) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick), .sw(sw),
    .we(we), .addr_x(addr_x), .addr_y(addr_y), .din(din),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (reset && we) begin
      wr_t e, a;
      we_cnt++;
      checks++;
      a = {addr_x, addr_y, din};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d din=%h, none expected", addr_x, addr_y, din);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL write_data: got x=%0d y=%0d din=%h, want x=%0d y=%0d din=%h",
                   addr_x, addr_y, din, e.x, e.y, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_cur(input string name, input int x, input int y);
    check({name, "_x"}, int'(cur_x), x);
    check({name, "_y"}, int'(cur_y), y);
  endtask

  task automatic pulse(input logic [2:0] b, input logic [6:0] s);
    @(negedge clk);
    btn_tick = b;
    sw = s;
    @(negedge clk);
    btn_tick = 3'b000;
  endtask

  task automatic advance_n(input int n);
    @(negedge clk);
    btn_tick = 3'b010;
    repeat (n) @(negedge clk);
    btn_tick = 3'b000;
  endtask

  task automatic push_clear();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        exp_q.push_back({7'(x), 5'(y), 7'h00});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, we_before;

    // Reset state
    #23;
    check("rst_we", int'(we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addr_x", int'(addr_x), 0);
    check("rst_addr_y", int'(addr_y), 0);
    check("rst_din", int'(din), 0);
    check_cur("rst_cur", 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Plain write: cursor still shows (0,0) while we is high, (1,0) afterwards
    exp_q.push_back({7'd0, 5'd0, 7'h41});
    pulse(3'b001, 7'h41);
    check_cur("wr_cur_during", 0, 0);
    @(negedge clk);
    check_cur("wr_cur_after", 1, 0);

    // Walk to the last cell, then wrap with an advance
    advance_n(2398);
    check_cur("walk_end", 79, 29);
    advance_n(1);
    check_cur("wrap", 0, 0);
    check("wrap_we", int'(we), 0);

    // Row step on write at end of row
    advance_n(479);
    check_cur("row5_end", 79, 5);
    exp_q.push_back({7'd79, 5'd5, 7'h5A});
    pulse(3'b001, 7'h5A);
    @(negedge clk);
    check_cur("row_step", 0, 6);

    // Request in the WRITE cycle is dropped; address/data hold once we drops
    exp_q.push_back({7'd0, 5'd6, 7'h11});
    @(negedge clk);
    btn_tick = 3'b001;
    sw = 7'h11;
    @(negedge clk);
    sw = 7'h22;
    @(negedge clk);
    btn_tick = 3'b000;
    @(negedge clk);
    check_cur("back2back", 1, 6);
    check("hold_addr_x", int'(addr_x), 0);
    check("hold_addr_y", int'(addr_y), 6);
    check("hold_din", int'(din), 7'h11);

    // All three requests together: clear only; a write mid-clear is ignored
    push_clear();
    we_before = we_cnt;
    pulse(3'b111, 7'h7F);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      btn_tick = (n == 100) ? 3'b001 : 3'b000;
      @(negedge clk);
    end
    btn_tick = 3'b000;
    check("clear_busy_cycles", n, 2400);
    check("clear_we_count", we_cnt - we_before, 2400);
    check("clear_done_we", int'(we), 0);
    check_cur("clear_cur", 0, 0);
    check("clear_queue_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("clear_no_extra", we_cnt - we_before, 2400);

    // Reset in the middle of a clear aborts the scan at once
    advance_n(3);
    check_cur("pre_clear2", 3, 0);
    push_clear();
    pulse(3'b100, 7'h00);
    repeat (499) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_we", int'(we), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_addr_x", int'(addr_x), 0);
    check_cur("rst_mid_cur", 0, 0);
    check("rst_mid_written", exp_q.size(), 1900);
    exp_q.delete();
    we_before = we_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back({7'd0, 5'd0, 7'h33});
    pulse(3'b001, 7'h33);
    @(negedge clk);
    check_cur("post_rst_wr", 1, 0);
    check("post_rst_we_count", we_cnt - we_before, 1);
    check("final_queue_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
